// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and constants for the round-robin shared-register arbiter.
package shared_reg_arbiter_pkg;

    localparam int ID_W          = 4;
    localparam int DEF_NREQ      = 16;
    localparam int DEF_WIDTH     = 4;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    // Index of the requester after idx, wrapping at n.
    function automatic logic [ID_W-1:0] next_index(input logic [ID_W-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + ID_W'(1);
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Request/ack bus between the requesters and the shared-register arbiter.
interface shared_reg_arbiter_if
    import shared_reg_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      d_out;
    logic                  wr_valid;
    logic [ID_W-1:0]       gnt_id;
    logic                  owner_locked;

    modport master (
        output req, lock, wdata,
        input  ack, d_out, wr_valid, gnt_id, owner_locked
    );

    modport slave (
        input  req, lock, wdata,
        output ack, d_out, wr_valid, gnt_id, owner_locked
    );
endinterface

// File: rtl/shared_reg_arbiter_picker.sv
// Combinational round-robin picker: first eligible index at or after pointer, wrapping.
module rr_priority_picker
    import shared_reg_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [ID_W-1:0] pointer,
    output logic            found,
    output logic [ID_W-1:0] winner
);
    logic [2*NREQ-1:0] doubled;
    logic [NREQ-1:0]   rotated;
    logic [ID_W:0]     sum;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        doubled = {eligible, eligible} >> pointer;
        rotated = doubled[NREQ-1:0];
        found   = 1'b0;
        winner  = '0;
        sum     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                sum   = {1'b0, pointer} + (ID_W+1)'(k);
                if (sum >= (ID_W+1)'(NREQ)) sum = sum - (ID_W+1)'(NREQ);
                winner = sum[ID_W-1:0];
            end
        end
    end
endmodule

// File: rtl/shared_reg_arbiter.sv
// One WIDTH-bit register shared by NREQ requesters: round-robin grant, one write per cycle, bounded burst lock.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input logic                 clk,
    input logic                 rst_n,
    shared_reg_arbiter_if.slave bus
);
    localparam logic [ID_W-1:0] MAX_CNT = ID_W'(MAX_BURST);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]  d_out_q, d_out_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;

    logic [NREQ-1:0]   eligible;
    logic              found;
    logic [ID_W-1:0]   pick;
    logic              do_write, release_lock;
    logic [ID_W-1:0]   wr_id;
    logic [WIDTH-1:0]  wdata_arr [NREQ];

    // A requester acked last cycle is masked so its still-high req cannot write twice.
    assign eligible = bus.req & ~ack_q;

    rr_priority_picker #(.NREQ(NREQ)) u_picker (
        .eligible (eligible),
        .pointer  (ptr_q),
        .found    (found),
        .winner   (pick)
    );

    always_comb begin
        for (int k = 0; k < NREQ; k++) wdata_arr[k] = bus.wdata[k*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        ack_d        = '0;
        d_out_d      = d_out_q;
        wr_valid_d   = 1'b0;
        gnt_id_d     = gnt_id_q;
        do_write     = 1'b0;
        release_lock = 1'b0;
        wr_id        = pick;

        case (state_q)
            IDLE: begin
                if (found) begin
                    do_write = 1'b1;
                    if (bus.lock[pick]) begin
                        owner_d = pick;
                        cnt_d   = ID_W'(1);
                        state_d = LOCKED;
                    end else begin
                        ptr_d = next_index(pick, NREQ);
                    end
                end
            end
            LOCKED: begin
                wr_id = owner_q;
                if (cnt_q >= MAX_CNT) begin
                    release_lock = 1'b1;
                end else if (eligible[owner_q]) begin
                    // A write with lock low is the owner's last one.
                    do_write     = 1'b1;
                    cnt_d        = cnt_q + ID_W'(1);
                    release_lock = !bus.lock[owner_q] || (cnt_d == MAX_CNT);
                end else if (!bus.req[owner_q] && !ack_q[owner_q]) begin
                    release_lock = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (release_lock) begin
            state_d = IDLE;
            ptr_d   = next_index(owner_q, NREQ);
        end

        if (do_write) begin
            ack_d[wr_id] = 1'b1;
            d_out_d      = wdata_arr[wr_id];
            wr_valid_d   = 1'b1;
            gnt_id_d     = wr_id;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            ack_q      <= '0;
            d_out_q    <= '0;
            wr_valid_q <= 1'b0;
            gnt_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            d_out_q    <= d_out_d;
            wr_valid_q <= wr_valid_d;
            gnt_id_q   <= gnt_id_d;
        end
    end

    assign bus.ack          = ack_q;
    assign bus.d_out        = d_out_q;
    assign bus.wr_valid     = wr_valid_q;
    assign bus.gnt_id       = gnt_id_q;
    assign bus.owner_locked = (state_q == LOCKED);
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: per-cycle reference model plus literal expectations.
module tb_shared_reg_arbiter;
    localparam int NREQ      = 16;
    localparam int WIDTH     = 4;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [NREQ-1:0] hold;
    int   gnt_log[$];
    int   exp_q[$];

    shared_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: outputs derived from the arbitration rules with integer arithmetic.
    int              m_ptr, m_owner, m_cnt, m_win, m_idx;
    bit              m_locked, m_release;
    logic [NREQ-1:0] m_ack;
    logic [WIDTH-1:0] m_dout;
    logic [3:0]      m_gnt;
    logic            m_wv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
            m_ack = '0; m_dout = '0; m_gnt = '0; m_wv = 1'b0;
        end else begin
            m_win = -1;
            m_release = 0;
            if (!m_locked) begin
                for (int k = 0; k < NREQ; k++) begin
                    m_idx = (m_ptr + k) % NREQ;
                    if (m_win < 0 && bus.req[4'(m_idx)] && !m_ack[4'(m_idx)]) m_win = m_idx;
                end
                if (m_win >= 0) begin
                    if (bus.lock[4'(m_win)]) begin
                        m_locked = 1; m_owner = m_win; m_cnt = 1;
                    end else begin
                        m_ptr = (m_win + 1) % NREQ;
                    end
                end
            end else if (m_cnt >= MAX_BURST) begin
                m_release = 1;
            end else if (bus.req[4'(m_owner)] && !m_ack[4'(m_owner)]) begin
                m_win = m_owner;
                m_cnt++;
                m_release = !bus.lock[4'(m_owner)] || (m_cnt == MAX_BURST);
            end else if (!bus.req[4'(m_owner)] && !m_ack[4'(m_owner)]) begin
                m_release = 1;
            end
            if (m_release) begin
                m_locked = 0;
                m_ptr = (m_owner + 1) % NREQ;
            end
            m_ack = '0;
            m_wv  = (m_win >= 0);
            if (m_win >= 0) begin
                m_ack[4'(m_win)] = 1'b1;
                m_dout = bus.wdata[m_win*WIDTH +: WIDTH];
                m_gnt  = 4'(m_win);
            end
        end
    end

    always @(negedge clk) begin
        check("ack", 32'(bus.ack), 32'(m_ack));
        check("d_out", 32'(bus.d_out), 32'(m_dout));
        check("wr_valid", 32'(bus.wr_valid), 32'(m_wv));
        check("gnt_id", 32'(bus.gnt_id), 32'(m_gnt));
        check("owner_locked", 32'(bus.owner_locked), 32'(m_locked));
        if (bus.wr_valid === 1'b1) gnt_log.push_back(int'(bus.gnt_id));
    end

    // Requesters drop req after their ack unless listed in hold.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.req = bus.req & ~(bus.ack & ~hold);
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < budget) begin
            tick();
            cyc++;
            if (bus.wr_valid === 1'b1) seen++;
        end
        check({name, " write count"}, 32'(seen), 32'(n));
    endtask

    task automatic check_log(input string name);
        @(negedge clk);
        #1;
        check({name, " length"}, 32'(gnt_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < gnt_log.size(); i++)
            check(name, 32'(gnt_log[i]), 32'(exp_q[i]));
        gnt_log.delete();
    endtask

    task automatic set_wdata(input int i, input logic [WIDTH-1:0] v);
        bus.wdata[i*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = '0; bus.lock = '0; bus.wdata = '0; hold = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset d_out", 32'(bus.d_out), 32'h0);
        check("reset ack", 32'(bus.ack), 32'h0);
        check("reset gnt_id", 32'(bus.gnt_id), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        gnt_log.delete();

        // Single request from requester 3.
        set_wdata(3, 4'h5);
        bus.req[3] = 1'b1;
        tick();
        check("single ack", 32'(bus.ack), 32'h0008);
        check("single d_out", 32'(bus.d_out), 32'h5);
        check("single gnt_id", 32'(bus.gnt_id), 32'h3);
        check("single wr_valid", 32'(bus.wr_valid), 32'h1);
        tick();
        check("single ack cleared", 32'(bus.ack), 32'h0);
        check("single wr_valid cleared", 32'(bus.wr_valid), 32'h0);
        gnt_log.delete();

        // Reset in the middle of a locked burst.
        set_wdata(6, 4'hA);
        bus.req[6] = 1'b1; bus.lock[6] = 1'b1; hold[6] = 1'b1;
        tick();
        check("pre-reset d_out", 32'(bus.d_out), 32'hA);
        check("pre-reset locked", 32'(bus.owner_locked), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset d_out", 32'(bus.d_out), 32'h0);
        check("async reset ack", 32'(bus.ack), 32'h0);
        check("async reset wr_valid", 32'(bus.wr_valid), 32'h0);
        check("async reset gnt_id", 32'(bus.gnt_id), 32'h0);
        check("async reset locked", 32'(bus.owner_locked), 32'h0);
        bus.req = '0; bus.lock = '0; hold = '0;
        @(negedge clk);
        rst_n = 1'b1;
        gnt_log.delete();

        // All requesters: grants rotate 0..15.
        for (int i = 0; i < NREQ; i++) set_wdata(i, WIDTH'(i ^ 5));
        bus.req = '1;
        wait_writes(NREQ, 40, "rr");
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) exp_q.push_back(i);
        check_log("rr order");

        // Pointer follows last grant: after 5, requester 9 precedes 2.
        bus.req[5] = 1'b1;
        wait_writes(1, 5, "ptr seed");
        bus.req[2] = 1'b1; bus.req[9] = 1'b1;
        wait_writes(2, 10, "ptr pair");
        exp_q = '{5, 9, 2};
        check_log("ptr order");

        // Burst lock: requester 7 gets MAX_BURST writes, then 1 is served.
        set_wdata(7, 4'hC); set_wdata(1, 4'h3);
        bus.req[7] = 1'b1; bus.lock[7] = 1'b1; hold[7] = 1'b1;
        bus.req[1] = 1'b1;
        wait_writes(5, 20, "burst");
        bus.req[7] = 1'b0; bus.lock[7] = 1'b0; hold[7] = 1'b0;
        exp_q = '{7, 7, 7, 7, 1};
        check_log("burst order");
        check("burst released", 32'(bus.owner_locked), 32'h0);

        // Early unlock after two writes: third write is final, pointer moves to 8.
        set_wdata(7, 4'h9);
        bus.req[7] = 1'b1; bus.lock[7] = 1'b1; hold[7] = 1'b1;
        wait_writes(2, 10, "early lock");
        check("early locked", 32'(bus.owner_locked), 32'h1);
        bus.lock[7] = 1'b0;
        set_wdata(7, 4'h6);
        wait_writes(1, 6, "early final");
        check("early final d_out", 32'(bus.d_out), 32'h6);
        check("early unlocked", 32'(bus.owner_locked), 32'h0);
        bus.req[7] = 1'b0; hold[7] = 1'b0;
        bus.req[0] = 1'b1; bus.req[8] = 1'b1;
        wait_writes(2, 10, "early after");
        exp_q = '{7, 7, 7, 8, 0};
        check_log("early order");

        // Lock without req has no effect.
        bus.lock[4] = 1'b1;
        repeat (3) tick();
        check("lock only wr_valid", 32'(bus.wr_valid), 32'h0);
        check("lock only locked", 32'(bus.owner_locked), 32'h0);
        bus.lock[4] = 1'b0;

        // Ack mask: a held request writes on alternate cycles.
        bus.req[0] = 1'b1; hold[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("ack mask pattern", 32'(bus.ack[0]), (k % 2 == 0) ? 32'h1 : 32'h0);
        end
        bus.req = '0; hold = '0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
